// File: rtl/fsm_step_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fsm_step_scheduler                                            |
// | Purpose  : Round-robin time-multiplexing of one 3-bit step unit over     |
// |            NUM_CH channel state registers. Optional: FSM_ILLEGAL_FLAG_EN |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fsm_step_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   req,
  input  logic [NUM_CH-1:0]   x_in,
  input  logic [NUM_CH-1:0]   clr,
  input  logic                load_en,
  input  logic [CH_W-1:0]     load_ch,
  input  logic [2:0]          load_state,
  output logic [NUM_CH-1:0]   grant,
  output logic                valid_out,
  output logic [CH_W-1:0]     ch_out,
  output logic                z_out,
  output logic [2:0]          state_out,
  output logic [3*NUM_CH-1:0] state_flat
`ifdef FSM_ILLEGAL_FLAG_EN
  ,
  output logic                err_out
`endif
);

  localparam logic [2:0] c_ST_000 = 3'b000;
  localparam logic [2:0] c_ST_001 = 3'b001;
  localparam logic [2:0] c_ST_010 = 3'b010;
  localparam logic [2:0] c_ST_011 = 3'b011;
  localparam logic [2:0] c_ST_100 = 3'b100;

  function automatic logic [2:0] f_next(input logic [2:0] y, input logic x);
    case (y)
      c_ST_000: f_next = x ? c_ST_001 : c_ST_000;
      c_ST_001: f_next = x ? c_ST_100 : c_ST_001;
      c_ST_010: f_next = x ? c_ST_001 : c_ST_010;
      c_ST_011: f_next = x ? c_ST_010 : c_ST_001;
      c_ST_100: f_next = x ? c_ST_100 : c_ST_011;
      default:  f_next = c_ST_000;
    endcase
  endfunction

  function automatic logic f_z(input logic [2:0] y);
    f_z = (y == c_ST_011) || (y == c_ST_100);
  endfunction

  logic [2:0]        r_state [NUM_CH];
  logic [CH_W-1:0]   r_ptr;
  logic              r_valid;
  logic [CH_W-1:0]   r_ch;
  logic              r_z;
  logic [2:0]        r_st;
  logic              r_err;

  logic [2:0]        w_state_nxt [NUM_CH];
  logic [CH_W-1:0]   w_ptr_nxt;
  logic              w_valid_nxt;
  logic [CH_W-1:0]   w_ch_nxt;
  logic              w_z_nxt;
  logic [2:0]        w_st_nxt;
  logic              w_err_nxt;

  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_gnt_oh;
  logic              w_gnt_any;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [CH_W-1:0]   w_cand;
  logic [2:0]        w_old;
  logic              w_x;
  logic [2:0]        w_new;

  // A channel being loaded or cleared this cycle must not also be stepped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_elig
    assign w_elig[i] = req[i] & ~clr[i] & ~(load_en & (load_ch == CH_W'(i)));
    assign state_flat[3*i +: 3] = r_state[i];
  end

  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_cand = CH_W'((int'(r_ptr) + k) % NUM_CH);
      if (!w_gnt_any && w_elig[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    w_gnt_oh = w_gnt_any ? (NUM_CH'(1) << w_gnt_idx) : '0;
  end

  always_comb begin
    w_old = c_ST_000;
    w_x   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_gnt_oh[i]) begin
        w_old = r_state[i];
        w_x   = x_in[i];
      end
    end
    w_new = f_next(w_old, w_x);
  end

  // Next-state: per-channel priority is load > clr > step.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      if (load_en && (load_ch == CH_W'(i)))
        w_state_nxt[i] = load_state;
      else if (clr[i])
        w_state_nxt[i] = c_ST_000;
      else if (w_gnt_oh[i])
        w_state_nxt[i] = w_new;
    end
    w_ptr_nxt   = w_gnt_any ? w_gnt_idx : r_ptr;
    w_valid_nxt = w_gnt_any;
    w_ch_nxt    = w_gnt_any ? w_gnt_idx : r_ch;
    w_z_nxt     = w_gnt_any ? f_z(w_old) : r_z;
    w_st_nxt    = w_gnt_any ? w_new : r_st;
    w_err_nxt   = w_gnt_any && (w_old > c_ST_100);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) r_state[i] <= c_ST_000;
      r_ptr   <= CH_W'(NUM_CH - 1);
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_z     <= 1'b0;
      r_st    <= c_ST_000;
      r_err   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) r_state[i] <= w_state_nxt[i];
      r_ptr   <= w_ptr_nxt;
      r_valid <= w_valid_nxt;
      r_ch    <= w_ch_nxt;
      r_z     <= w_z_nxt;
      r_st    <= w_st_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    grant     = reset ? '0 : w_gnt_oh;
    valid_out = r_valid;
    ch_out    = r_ch;
    z_out     = r_z;
    state_out = r_st;
  end

`ifdef FSM_ILLEGAL_FLAG_EN
  assign err_out = r_err;
`else
  logic w_err_unused;
  assign w_err_unused = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsm_step_scheduler.sv
`default_nettype none
// Testbench for fsm_step_scheduler: reference model feeds an expectation
// queue that a negedge monitor drains; scenario tasks add literal checks.
module tb_fsm_step_scheduler;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, x_in, clr;
  logic        load_en;
  logic [1:0]  load_ch;
  logic [2:0]  load_state;
  logic [3:0]  grant;
  logic        valid_out;
  logic [1:0]  ch_out;
  logic        z_out;
  logic [2:0]  state_out;
  logic [11:0] state_flat;
  logic        err_out;

  always #5 clk = ~clk;

  fsm_step_scheduler #(.NUM_CH(N), .CH_W(2)) dut (
    .clk(clk), .reset(reset), .req(req), .x_in(x_in), .clr(clr),
    .load_en(load_en), .load_ch(load_ch), .load_state(load_state),
    .grant(grant), .valid_out(valid_out), .ch_out(ch_out), .z_out(z_out),
    .state_out(state_out), .state_flat(state_flat)
`ifdef FSM_ILLEGAL_FLAG_EN
    , .err_out(err_out)
`endif
  );
`ifndef FSM_ILLEGAL_FLAG_EN
  assign err_out = 1'b0;
`endif

  typedef struct {
    logic        valid;
    logic [1:0]  ch;
    logic        z;
    logic [2:0]  st;
    logic [11:0] flat;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference table indexed by pre-step state.
  logic [2:0] n0_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd3, 3'd0, 3'd0, 3'd0};
  logic [2:0] n1_tab [8] = '{3'd1, 3'd4, 3'd1, 3'd2, 3'd4, 3'd0, 3'd0, 3'd0};
  logic       z_tab  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic [2:0] m_state [N];
  int         m_ptr;
  exp_t       m_out;

  task automatic step(input logic rs, input logic [3:0] rq, input logic [3:0] xv,
                      input logic [3:0] cl, input logic le, input logic [1:0] lc,
                      input logic [2:0] ls, output logic [3:0] g_obs,
                      output logic [3:0] g_exp);
    int gi;
    logic [2:0] old;
    logic [2:0] nst [N];
    reset = rs; req = rq; x_in = xv; clr = cl;
    load_en = le; load_ch = lc; load_state = ls;
    #1;
    g_obs = grant;
    g_exp = 4'b0000;
    gi = -1;
    if (!rs) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (gi < 0 && rq[idx] && !cl[idx] && !(le && int'(lc) == idx)) begin
          gi = idx;
          g_exp[idx] = 1'b1;
        end
      end
    end
    if (rs) begin
      for (int i = 0; i < N; i++) nst[i] = 3'd0;
      m_ptr = N - 1;
      m_out.valid = 1'b0; m_out.ch = 2'd0; m_out.z = 1'b0;
      m_out.st = 3'd0; m_out.err = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) nst[i] = m_state[i];
      m_out.valid = 1'b0;
      m_out.err   = 1'b0;
      if (gi >= 0) begin
        old = m_state[gi];
        m_out.valid = 1'b1;
        m_out.ch    = 2'(gi);
        m_out.z     = z_tab[old];
        m_out.st    = xv[gi] ? n1_tab[old] : n0_tab[old];
        m_out.err   = (old > 3'd4);
        nst[gi]     = m_out.st;
        m_ptr       = gi;
      end
      for (int i = 0; i < N; i++) if (cl[i]) nst[i] = 3'd0;
      if (le) nst[lc] = ls;
    end
    for (int i = 0; i < N; i++) begin
      m_state[i] = nst[i];
      m_out.flat[3*i +: 3] = nst[i];
    end
    @(posedge clk);
    sb.push_back(m_out);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (valid_out !== e.valid || ch_out !== e.ch || z_out !== e.z ||
          state_out !== e.st || state_flat !== e.flat) begin
        failures++;
        $display("FAIL scoreboard: got v=%b ch=%0d z=%b st=%b flat=%h, want v=%b ch=%0d z=%b st=%b flat=%h",
                 valid_out, ch_out, z_out, state_out, state_flat,
                 e.valid, e.ch, e.z, e.st, e.flat);
      end
`ifdef FSM_ILLEGAL_FLAG_EN
      checks++;
      if (err_out !== e.err) begin
        failures++;
        $display("FAIL scoreboard_err: got %b want %b", err_out, e.err);
      end
`endif
    end
  end

  logic [3:0] go, ge;

  task automatic test_reset();
    step(1'b1, 4'b1111, 4'b0, 4'b0, 1'b0, 2'd0, 3'd0, go, ge);
    checks++;
    if (go !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b want 0000", go); end
    step(1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 2'd0, 3'd0, go, ge);
    checks++;
    if (valid_out !== 1'b0 || state_flat !== 12'h000 || ch_out !== 2'd0 || state_out !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: got v=%b flat=%h ch=%0d st=%b want 0 000 0 000", valid_out, state_flat, ch_out, state_out);
    end
  endtask

  task automatic test_single();
    logic [2:0] st_exp [3];
    logic       z_exp  [3];
    st_exp = '{3'b001, 3'b100, 3'b100};
    z_exp  = '{1'b0, 1'b0, 1'b1};
    step(1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 2'd0, 3'd0, go, ge);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 4'b0001, 4'b0001, 4'b0, 1'b0, 2'd0, 3'd0, go, ge);
      checks++;
      if (go !== 4'b0001) begin failures++; $display("FAIL single_grant[%0d]: got %b want 0001", c, go); end
      checks++;
      if (state_out !== st_exp[c] || z_out !== z_exp[c]) begin
        failures++;
        $display("FAIL single_result[%0d]: got st=%b z=%b want st=%b z=%b", c, state_out, z_out, st_exp[c], z_exp[c]);
      end
    end
    checks++;
    if (state_flat[2:0] !== 3'b100) begin failures++; $display("FAIL single_flat: got %b want 100", state_flat[2:0]); end
  endtask

  task automatic test_round_robin();
    logic [3:0] g_seq [5];
    g_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    step(1'b1, 4'b0, 4'b0, 4'b0, 1'b0, 2'd0, 3'd0, go, ge);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 4'b1111, 4'b0000, 4'b0, 1'b0, 2'd0, 3'd0, go, ge);
      checks++;
      if (go !== g_seq[c] || ch_out !== 2'(c % 4)) begin
        failures++;
        $display("FAIL rr[%0d]: got grant=%b ch=%0d want grant=%b ch=%0d", c, go, ch_out, g_seq[c], c % 4);
      end
    end
    checks++;
    if (state_flat !== 12'h000) begin failures++; $display("FAIL rr_states: got %h want 000", state_flat); end
  endtask

  task automatic test_load_step();
    step(1'b0, 4'b0, 4'b0, 4'b0, 1'b1, 2'd2, 3'b011, go, ge);
    step(1'b0, 4'b0100, 4'b0100, 4'b0, 1'b0, 2'd0, 3'd0, go, ge);
    checks++;
    if (valid_out !== 1'b1 || ch_out !== 2'd2 || z_out !== 1'b1 || state_out !== 3'b010) begin
      failures++;
      $display("FAIL load_step: got v=%b ch=%0d z=%b st=%b want 1 2 1 010", valid_out, ch_out, z_out, state_out);
    end
  endtask

  task automatic test_clr();
    step(1'b0, 4'b0, 4'b0, 4'b0, 1'b1, 2'd1, 3'b100, go, ge);
    step(1'b0, 4'b0010, 4'b0, 4'b0010, 1'b0, 2'd0, 3'd0, go, ge);
    checks++;
    if (go !== 4'b0000) begin failures++; $display("FAIL clr_grant: got %b want 0000", go); end
    checks++;
    if (valid_out !== 1'b0 || state_flat[5:3] !== 3'b000) begin
      failures++;
      $display("FAIL clr_result: got v=%b ch1=%b want 0 000", valid_out, state_flat[5:3]);
    end
  endtask

  task automatic test_illegal();
    step(1'b0, 4'b0, 4'b0, 4'b0, 1'b1, 2'd3, 3'b110, go, ge);
    step(1'b0, 4'b1000, 4'b1000, 4'b0, 1'b0, 2'd0, 3'd0, go, ge);
    checks++;
    if (valid_out !== 1'b1 || state_out !== 3'b000 || z_out !== 1'b0) begin
      failures++;
      $display("FAIL illegal: got v=%b st=%b z=%b want 1 000 0", valid_out, state_out, z_out);
    end
`ifdef FSM_ILLEGAL_FLAG_EN
    checks++;
    if (err_out !== 1'b1) begin failures++; $display("FAIL illegal_err: got %b want 1", err_out); end
`endif
  endtask

  task automatic test_concurrent();
    step(1'b0, 4'b0, 4'b0, 4'b0, 1'b1, 2'd1, 3'b010, go, ge);
    step(1'b0, 4'b0111, 4'b0100, 4'b0010, 1'b1, 2'd0, 3'b011, go, ge);
    checks++;
    if (go !== 4'b0100) begin failures++; $display("FAIL concurrent_grant: got %b want 0100", go); end
  endtask

  task automatic test_reset_midstream();
    for (int c = 0; c < 3; c++) step(1'b0, 4'b1111, 4'b1111, 4'b0, 1'b0, 2'd0, 3'd0, go, ge);
    step(1'b1, 4'b1111, 4'b1111, 4'b0, 1'b0, 2'd0, 3'd0, go, ge);
    checks++;
    if (go !== 4'b0000) begin failures++; $display("FAIL mid_reset_grant: got %b want 0000", go); end
    checks++;
    if (valid_out !== 1'b0 || state_flat !== 12'h000) begin
      failures++;
      $display("FAIL mid_reset_state: got v=%b flat=%h want 0 000", valid_out, state_flat);
    end
    step(1'b0, 4'b1111, 4'b0000, 4'b0, 1'b0, 2'd0, 3'd0, go, ge);
    checks++;
    if (go !== 4'b0001) begin failures++; $display("FAIL mid_reset_first: got %b want 0001", go); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 60; c++) begin
      step(1'b0, 4'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
           ($urandom_range(0, 3) == 0), 2'($urandom), 3'($urandom), go, ge);
      checks++;
      if (go !== ge) begin failures++; $display("FAIL random_grant[%0d]: got %b want %b", c, go, ge); end
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; x_in = '0; clr = '0;
    load_en = 1'b0; load_ch = '0; load_state = '0;
    for (int i = 0; i < N; i++) m_state[i] = 3'd0;
    m_ptr = N - 1;
    test_reset();
    test_single();
    test_round_robin();
    test_load_step();
    test_clr();
    test_illegal();
    test_concurrent();
    test_reset_midstream();
    test_random();
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
